// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: sizes, round constants, sigma functions and the
// expander state encoding.
package sha256_pkg;

  localparam int SHA256_ROUNDS = 64;
  localparam int SHA256_WORD_W = 32;
  localparam int SHA256_WIN    = 16;

  typedef logic [SHA256_WORD_W-1:0] word_t;

  typedef enum logic {IDLE, STREAM} exp_state_t;

  localparam word_t K [SHA256_ROUNDS] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // Message-schedule small sigmas.
  function automatic word_t sigma0(input word_t x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic word_t sigma1(input word_t x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  // Compression-round big sigmas.
  function automatic word_t big_sigma0(input word_t x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic word_t big_sigma1(input word_t x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

endpackage

// File: rtl/sha256_k_rom.sv
// Combinational round-constant ROM: K[index].
module sha256_k_rom
  import sha256_pkg::*;
(
  input  logic [5:0] index,
  output word_t      k
);

  // Constant lookup by round index.
  always_comb begin
    // NOTE: default assigned first so no path leaves k unassigned and no latch is inferred.
    k = '0;
    case (index)
      6'd0:  k = 32'h428a2f98;  6'd1:  k = 32'h71374491;  6'd2:  k = 32'hb5c0fbcf;  6'd3:  k = 32'he9b5dba5;
      6'd4:  k = 32'h3956c25b;  6'd5:  k = 32'h59f111f1;  6'd6:  k = 32'h923f82a4;  6'd7:  k = 32'hab1c5ed5;
      6'd8:  k = 32'hd807aa98;  6'd9:  k = 32'h12835b01;  6'd10: k = 32'h243185be;  6'd11: k = 32'h550c7dc3;
      6'd12: k = 32'h72be5d74;  6'd13: k = 32'h80deb1fe;  6'd14: k = 32'h9bdc06a7;  6'd15: k = 32'hc19bf174;
      6'd16: k = 32'he49b69c1;  6'd17: k = 32'hefbe4786;  6'd18: k = 32'h0fc19dc6;  6'd19: k = 32'h240ca1cc;
      6'd20: k = 32'h2de92c6f;  6'd21: k = 32'h4a7484aa;  6'd22: k = 32'h5cb0a9dc;  6'd23: k = 32'h76f988da;
      6'd24: k = 32'h983e5152;  6'd25: k = 32'ha831c66d;  6'd26: k = 32'hb00327c8;  6'd27: k = 32'hbf597fc7;
      6'd28: k = 32'hc6e00bf3;  6'd29: k = 32'hd5a79147;  6'd30: k = 32'h06ca6351;  6'd31: k = 32'h14292967;
      6'd32: k = 32'h27b70a85;  6'd33: k = 32'h2e1b2138;  6'd34: k = 32'h4d2c6dfc;  6'd35: k = 32'h53380d13;
      6'd36: k = 32'h650a7354;  6'd37: k = 32'h766a0abb;  6'd38: k = 32'h81c2c92e;  6'd39: k = 32'h92722c85;
      6'd40: k = 32'ha2bfe8a1;  6'd41: k = 32'ha81a664b;  6'd42: k = 32'hc24b8b70;  6'd43: k = 32'hc76c51a3;
      6'd44: k = 32'hd192e819;  6'd45: k = 32'hd6990624;  6'd46: k = 32'hf40e3585;  6'd47: k = 32'h106aa070;
      6'd48: k = 32'h19a4c116;  6'd49: k = 32'h1e376c08;  6'd50: k = 32'h2748774c;  6'd51: k = 32'h34b0bcb5;
      6'd52: k = 32'h391c0cb3;  6'd53: k = 32'h4ed8aa4a;  6'd54: k = 32'h5b9cca4f;  6'd55: k = 32'h682e6ff3;
      6'd56: k = 32'h748f82ee;  6'd57: k = 32'h78a5636f;  6'd58: k = 32'h84c87814;  6'd59: k = 32'h8cc70208;
      6'd60: k = 32'h90befffa;  6'd61: k = 32'ha4506ceb;  6'd62: k = 32'hbef9a3f7;  6'd63: k = 32'hc67178f2;
      default: k = '0;
    endcase
  end

endmodule

// File: rtl/sha256_w_stream_expander.sv
// Iterative SHA-256 message scheduler: takes one 512-bit block and streams
// W_0..W_63 with K_t and t over a valid/ready interface, using a 16-word
// sliding window where window[j] always holds W_{t+j}.
module sha256_w_stream_expander
  import sha256_pkg::*;
(
  input  logic         CLK,
  input  logic         RST,
  input  logic         block_valid,
  output logic         block_ready,
  input  logic [511:0] block_in,
  output logic         w_valid,
  input  logic         w_ready,
  output logic [31:0]  w_out,
  output logic [31:0]  k_out,
  output logic [5:0]   w_index,
  output logic         w_last
);

  exp_state_t state_q, state_d;
  logic       block_ready_q;
  logic [5:0] t_q;
  word_t      window_q [SHA256_WIN];
  word_t      new_word;
  logic       accept;
  logic       advance;

  assign accept  = (state_q == IDLE) && block_valid && block_ready_q;
  assign advance = (state_q == STREAM) && w_ready;

  // Next schedule word; also computed for t >= 48 where it is never presented.
  assign new_word = sigma1(window_q[14]) + window_q[9] + sigma0(window_q[1]) + window_q[0];

  // Next-state logic: load a block from IDLE, return after the t = 63 handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = STREAM;
      STREAM:  if (advance && (t_q == 6'd63)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register and registered block_ready (high whenever the next state is IDLE).
  always_ff @(posedge CLK) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!RST) begin
      state_q       <= IDLE;
      block_ready_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      block_ready_q <= (state_d == IDLE);
    end
  end

  // Round counter and sliding window: parallel load on accept, shift on handshake.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      t_q <= '0;
      // NOTE: the window is cleared on reset only because w_out must read 0 afterwards.
      for (int i = 0; i < SHA256_WIN; i++) window_q[i] <= '0;
    end else if (accept) begin
      t_q <= '0;
      for (int i = 0; i < SHA256_WIN; i++) window_q[i] <= block_in[(SHA256_WIN-1-i)*32 +: 32];
    end else if (advance) begin
      t_q <= t_q + 6'd1;
      for (int i = 0; i < SHA256_WIN-1; i++) window_q[i] <= window_q[i+1];
      window_q[SHA256_WIN-1] <= new_word;
    end
  end

  sha256_k_rom u_k_rom (
    .index (t_q),
    .k     (k_out)
  );

  assign block_ready = block_ready_q;
  assign w_valid     = (state_q == STREAM);
  assign w_out       = window_q[0];
  assign w_index     = t_q;
  assign w_last      = (state_q == STREAM) && (t_q == 6'd63);

endmodule

// File: tb/tb_sha256_w_stream_expander.sv
// Self-checking bench for sha256_w_stream_expander: directed "abc" vectors,
// backpressure, back-to-back blocks, mid-stream reset and random blocks.
module tb_sha256_w_stream_expander;

  logic         CLK = 1'b0;
  logic         RST;
  logic         block_valid;
  logic         block_ready;
  logic [511:0] block_in;
  logic         w_valid;
  logic         w_ready;
  logic [31:0]  w_out;
  logic [31:0]  k_out;
  logic [5:0]   w_index;
  logic         w_last;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [31:0] K_TB [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef struct {
    int          t;
    logic [31:0] w;
    logic [31:0] k;
    logic        last;
    bit          chk_w;
  } vec_t;

  vec_t        vec [8];
  logic [31:0] exp_w [64];
  logic [31:0] cap_w [64];
  logic [31:0] cap_k [64];
  logic [5:0]  cap_i [64];
  logic        cap_last [64];

  sha256_w_stream_expander dut (
    .CLK         (CLK),
    .RST         (RST),
    .block_valid (block_valid),
    .block_ready (block_ready),
    .block_in    (block_in),
    .w_valid     (w_valid),
    .w_ready     (w_ready),
    .w_out       (w_out),
    .k_out       (k_out),
    .w_index     (w_index),
    .w_last      (w_last)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ref_s0(input logic [31:0] x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ref_s1(input logic [31:0] x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction

  // Reference schedule in the textbook W_t recurrence form.
  task automatic build_schedule(input logic [511:0] blk);
    for (int t = 0; t < 16; t++) exp_w[t] = blk[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++)
      exp_w[t] = ref_s1(exp_w[t-2]) + exp_w[t-7] + ref_s0(exp_w[t-15]) + exp_w[t-16];
  endtask

  // Entered just after a negedge; returns just after the negedge following the accept edge.
  task automatic accept_block(input logic [511:0] blk, input bit keep_valid);
    int waited;
    waited = 0;
    while (!block_ready && waited < 8) begin
      @(negedge CLK);
      waited++;
    end
    check("accept_ready", {31'd0, block_ready}, 32'd1);
    block_in    = blk;
    block_valid = 1'b1;
    @(negedge CLK);
    if (!keep_valid) block_valid = 1'b0;
  endtask

  // mode 0: w_ready high; 1: random stalls; 2: 5-cycle stall at t=20; 3: change block_in at t=10.
  task automatic receive_stream(input logic [511:0] blk, input int mode, output int cycles);
    int          n, cyc, stall_cnt;
    bit          done;
    logic        rdy;
    logic [31:0] hold_w, hold_k;
    logic [5:0]  hold_i;
    n = 0; cyc = 0; stall_cnt = 0; done = 1'b0;
    hold_w = '0; hold_k = '0; hold_i = '0;
    build_schedule(blk);
    while (!done && cyc < 400) begin
      check("w_valid", {31'd0, w_valid}, 32'd1);
      rdy = 1'b1;
      if (mode == 1) rdy = ($urandom_range(15) != 0);
      if (mode == 2 && n == 20) begin
        if (stall_cnt == 0) begin
          hold_w = w_out; hold_k = k_out; hold_i = w_index;
        end else begin
          check("stall_w_out", w_out, hold_w);
          check("stall_k_out", k_out, hold_k);
          check("stall_index", {26'd0, w_index}, {26'd0, hold_i});
          check("stall_index_20", {26'd0, w_index}, 32'd20);
        end
        if (stall_cnt < 5) begin
          rdy = 1'b0;
          stall_cnt++;
        end
      end
      if (mode == 3 && n == 10) block_in = ~blk;
      w_ready = rdy;
      if (w_valid && rdy && n < 64) begin
        cap_w[n] = w_out; cap_k[n] = k_out; cap_i[n] = w_index; cap_last[n] = w_last;
        check($sformatf("w_out[%0d]", n), w_out, exp_w[n]);
        check($sformatf("k_out[%0d]", n), k_out, K_TB[n]);
        check($sformatf("w_index[%0d]", n), {26'd0, w_index}, n);
        check($sformatf("w_last[%0d]", n), {31'd0, w_last}, {31'd0, (n == 63)});
        n++;
        done = (n == 64) || w_last;
      end
      cyc++;
      @(negedge CLK);
    end
    w_ready = 1'b0;
    check("handshakes", n, 64);
    cycles = cyc;
  endtask

  initial begin
    logic [511:0] abc, blk_a, blk_b;
    int           cyc;

    abc = '0;
    abc[511:480] = 32'h61626380;
    abc[31:0]    = 32'h00000018;

    vec[0] = '{0,  32'h61626380, 32'h428a2f98, 1'b0, 1'b1};
    vec[1] = '{1,  32'h00000000, 32'h71374491, 1'b0, 1'b1};
    vec[2] = '{14, 32'h00000000, 32'h9bdc06a7, 1'b0, 1'b1};
    vec[3] = '{15, 32'h00000018, 32'hc19bf174, 1'b0, 1'b1};
    vec[4] = '{16, 32'h61626380, 32'he49b69c1, 1'b0, 1'b1};
    vec[5] = '{17, 32'h000f0000, 32'hefbe4786, 1'b0, 1'b1};
    vec[6] = '{62, 32'h00000000, 32'hbef9a3f7, 1'b0, 1'b0};
    vec[7] = '{63, 32'h00000000, 32'hc67178f2, 1'b1, 1'b0};

    // Reset state.
    RST = 1'b0; block_valid = 1'b0; block_in = '0; w_ready = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_w_valid", {31'd0, w_valid}, 32'd0);
    check("rst_block_ready", {31'd0, block_ready}, 32'd0);
    check("rst_w_out", w_out, 32'd0);
    check("rst_w_index", {26'd0, w_index}, 32'd0);
    check("rst_w_last", {31'd0, w_last}, 32'd0);
    check("rst_k_out", k_out, 32'h428a2f98);
    RST = 1'b1;
    check("release_block_ready_low", {31'd0, block_ready}, 32'd0);
    @(negedge CLK);
    check("release_block_ready_high", {31'd0, block_ready}, 32'd1);

    // "abc" block, w_ready held high, plus the directed vector table.
    accept_block(abc, 1'b0);
    receive_stream(abc, 0, cyc);
    check("abc_cycles", cyc, 64);
    for (int i = 0; i < 8; i++) begin
      if (vec[i].chk_w) check($sformatf("vec_w[%0d]", vec[i].t), cap_w[vec[i].t], vec[i].w);
      check($sformatf("vec_k[%0d]", vec[i].t), cap_k[vec[i].t], vec[i].k);
      check($sformatf("vec_idx[%0d]", vec[i].t), {26'd0, cap_i[vec[i].t]}, vec[i].t);
      check($sformatf("vec_last[%0d]", vec[i].t), {31'd0, cap_last[vec[i].t]}, {31'd0, vec[i].last});
    end

    // Backpressure: 5-cycle stall at t = 20; 69 cycles from accept to last handshake.
    accept_block(abc, 1'b0);
    receive_stream(abc, 2, cyc);
    check("stall_cycles", cyc, 69);

    // Back-to-back blocks with block_valid held high; block_in changes mid-stream.
    for (int i = 0; i < 16; i++) begin
      blk_a[32*i +: 32] = $urandom();
      blk_b[32*i +: 32] = $urandom();
    end
    accept_block(blk_a, 1'b1);
    receive_stream(blk_a, 3, cyc);
    check("b2b_ready_after_last", {31'd0, block_ready}, 32'd1);
    check("b2b_idle_after_last", {31'd0, w_valid}, 32'd0);
    block_in = blk_b;
    @(negedge CLK);
    block_valid = 1'b0;
    check("b2b_accept_next_cycle", {31'd0, w_valid}, 32'd1);
    receive_stream(blk_b, 0, cyc);
    check("b2b_second_cycles", cyc, 64);

    // Reset while t = 30 is presented.
    accept_block(abc, 1'b0);
    w_ready = 1'b1;
    for (int i = 0; i < 30; i++) @(negedge CLK);
    check("mid_index_30", {26'd0, w_index}, 32'd30);
    RST = 1'b0;
    @(negedge CLK);
    check("mid_rst_w_valid", {31'd0, w_valid}, 32'd0);
    check("mid_rst_w_index", {26'd0, w_index}, 32'd0);
    check("mid_rst_w_out", w_out, 32'd0);
    check("mid_rst_block_ready", {31'd0, block_ready}, 32'd0);
    check("mid_rst_k_out", k_out, 32'h428a2f98);
    w_ready = 1'b0;
    RST = 1'b1;
    @(negedge CLK);
    check("mid_release_block_ready", {31'd0, block_ready}, 32'd1);
    accept_block(blk_b, 1'b0);
    receive_stream(blk_b, 0, cyc);

    // Random blocks with random stalls.
    for (int b = 0; b < 1000; b++) begin
      for (int i = 0; i < 16; i++) blk_a[32*i +: 32] = $urandom();
      accept_block(blk_a, 1'b0);
      receive_stream(blk_a, 1, cyc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
